dtree_class_histogram: RTL and testbench
========================================

Name: dtree_class_histogram

Overview:
- Sits directly downstream of dtree and consumes its per-classification result (level, path, out_valid).
- Accumulates a per-leaf histogram over a window of WINDOW_EVENTS classifications.
- At window close, snapshots the histogram into a second bank and streams it out bin by bin over a valid/ready interface, while counting of the next window continues uninterrupted.

Parameters:
- COUNT_WIDTH, 8, width of each bin counter and of out_count; counters saturate.
- WINDOW_EVENTS, 64, number of accepted classifications per window; legal range 1 to 2^16.
- OVR_WIDTH, 8, width of the saturating overrun counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising clk edge resets the block.
- level  in  2  dtree result: leaf depth.
- path  in  2  dtree result: branch bits.
- in_valid  in  1  driven by dtree out_valid; one classification per cycle when high.
- out_bin  out  4  bin index of the current output beat, {level,path}.
- out_count  out  COUNT_WIDTH  snapshot count for out_bin.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  high on the beat with out_bin==15.
- overrun  out  OVR_WIDTH  saturating count of windows dropped because the previous snapshot was still draining.

Behaviour:
- Bin index is {level,path}, giving 16 bins.
- Reset (reset==0 at clk edge): all live bins = 0; snapshot bank = 0; window counter = 0; state = IDLE; out_valid = 0; out_bin = 0; out_last = 0; overrun = 0.
- Reset mid-drain aborts the stream immediately; no further beats are produced.
- Live accumulation:
  - in_valid=1 increments live[{level,path}] by 1, saturating at 2^COUNT_WIDTH-1.
  - The window counter increments on every in_valid.
- Window close: the in_valid cycle on which the window counter equals WINDOW_EVENTS-1.
  - That event is included in the closing window.
  - Window counter returns to 0.
  - All live bins clear at the same edge, so the next event starts at 1.
  - If state==IDLE: snapshot <= live contents including the closing event; next cycle state = DRAIN with out_valid=1, out_bin=0. Latency is 1 cycle from the closing in_valid edge to out_valid.
  - If state==DRAIN: the snapshot is not overwritten; overrun increments, saturating at 2^OVR_WIDTH-1; live bins still clear.
- State machine:
  - IDLE: out_valid=0. Goes to DRAIN on window close.
  - DRAIN: out_valid=1; out_count = snapshot[out_bin]; out_last = (out_bin==15).
  - When out_valid & out_ready and out_bin<15: out_bin increments.
  - When out_valid & out_ready and out_bin==15: go to IDLE and out_bin returns to 0.
  - When out_ready=0: out_bin, out_count and out_last hold stable (AXI-style). out_valid never drops mid-stream.
- Window close on the same cycle as the final (bin 15) handshake: counts as DRAIN, so the window is dropped and overrun increments. This keeps the rule simple and cycle-exact.
- in_valid and out_ready are fully independent; accumulation never stalls.
- out_count is registered; the outputs have no combinational path from in_valid, level or path.

Decomposition:
- Shared package dtree_pkg:
  - NUM_BINS=16 and BIN_WIDTH=4.
  - Bin-index function bin_of(level,path).
  - State enum {S_IDLE, S_DRAIN}.
- One natural sub-module: dtree_sat_counter, a parameterised-width saturating incrementer with synchronous clear. It is instantiated for the 16 live bins, the window counter (wrapping mode) and overrun.

Test Plan:
- WINDOW_EVENTS=4; feed (level,path)=(1,2),(1,2),(3,0),(0,0) with out_ready=1. Required: one cycle after the 4th event, 16 beats: bin 6 count 2, bin 12 count 1, bin 0 count 1, all others 0; out_last only on bin 15; overrun=0.
- COUNT_WIDTH=3, WINDOW_EVENTS=20; all 20 events to bin 5. Required: bin 5 reports 7 (saturated); all other bins 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises, then toggle it 1/0. Required: out_bin and out_count stable while not ready; exactly 16 handshakes; out_bin sequence 0..15 with no skips or repeats.
- Overrun: WINDOW_EVENTS=4, out_ready=0 throughout, 8 consecutive events. Required: overrun=1; the snapshot still reports the first window's counts once out_ready is raised.
- Drop on final handshake: arrange a window close on the same edge as the bin-15 handshake. Required: overrun increments by 1 and out_valid=0 on the next cycle.
- Reset mid-drain: assert reset=0 at beat 5. Required: next cycle out_valid=0 and overrun=0; after release, the first window (4 events to bin 3) reports bin 3 count 4 and no stale counts.

Source files
------------

// File: rtl/dtree_pkg.sv
// Shared bin geometry, bin-index helper and drain state encoding for the dtree histogram blocks.
package dtree_pkg;

  localparam int NUM_BINS  = 16;
  localparam int BIN_WIDTH = 4;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  function automatic logic [BIN_WIDTH-1:0] bin_of(input logic [1:0] level, input logic [1:0] path);
    return {level, path};
  endfunction

endpackage

// File: rtl/dtree_sat_counter.sv
// Saturating (or wrapping) incrementer with synchronous clear; clear wins over increment.
// Latency 1 cycle from inc/clr to count; no backpressure.
module dtree_sat_counter #(
  parameter int WIDTH = 8,
  parameter bit WRAP  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (WRAP || (count_q != {WIDTH{1'b1}}))) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dtree_class_histogram.sv
// Per-leaf histogram over fixed windows; snapshot streamed out one bin per beat.
// Latency 1 cycle close->out_valid; out_ready stalls only the stream, never accumulation.
module dtree_class_histogram
  import dtree_pkg::*;
#(
  parameter int COUNT_WIDTH   = 8,
  parameter int WINDOW_EVENTS = 64,
  parameter int OVR_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             level,
  input  logic [1:0]             path,
  input  logic                   in_valid,
  output logic [BIN_WIDTH-1:0]   out_bin,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [OVR_WIDTH-1:0]   overrun
);

  localparam int WIN_W = (WINDOW_EVENTS > 1) ? $clog2(WINDOW_EVENTS) : 1;

  logic [BIN_WIDTH-1:0]   bin;
  logic [WIN_W-1:0]       win_cnt;
  logic                   win_close;
  logic                   ovr_inc;
  logic [COUNT_WIDTH-1:0] live     [NUM_BINS];
  logic [COUNT_WIDTH-1:0] live_inc [NUM_BINS];

  state_t                 state_q,     state_d;
  logic [BIN_WIDTH-1:0]   out_bin_q,   out_bin_d;
  logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
  logic [COUNT_WIDTH-1:0] snap_q [NUM_BINS];
  logic [COUNT_WIDTH-1:0] snap_d [NUM_BINS];
  logic [BIN_WIDTH-1:0]   bin_next;

  assign bin       = bin_of(level, path);
  assign win_close = in_valid && (win_cnt == WIN_W'(WINDOW_EVENTS - 1));
  assign bin_next  = out_bin_q + BIN_WIDTH'(1);

  for (genvar b = 0; b < NUM_BINS; b++) begin : g_live
    dtree_sat_counter #(.WIDTH(COUNT_WIDTH), .WRAP(1'b0)) u_bin (
      .clk   (clk),
      .reset (reset),
      .clr   (win_close),
      .inc   (in_valid && (bin == BIN_WIDTH'(b))),
      .count (live[b])
    );
  end

  dtree_sat_counter #(.WIDTH(WIN_W), .WRAP(1'b1)) u_win (
    .clk   (clk),
    .reset (reset),
    .clr   (win_close),
    .inc   (in_valid),
    .count (win_cnt)
  );

  dtree_sat_counter #(.WIDTH(OVR_WIDTH), .WRAP(1'b0)) u_ovr (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (ovr_inc),
    .count (overrun)
  );

  // Live value as it will be after this edge's event, so the closing event lands in the snapshot.
  always_comb begin
    for (int b = 0; b < NUM_BINS; b++) begin
      live_inc[b] = live[b];
      if (in_valid && (bin == BIN_WIDTH'(b)) && (live[b] != {COUNT_WIDTH{1'b1}})) begin
        live_inc[b] = live[b] + COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_bin_d   = out_bin_q;
    out_count_d = out_count_q;
    ovr_inc     = 1'b0;
    for (int b = 0; b < NUM_BINS; b++) begin
      snap_d[b] = snap_q[b];
    end

    case (state_q)
      S_IDLE: begin
        if (win_close) begin
          for (int b = 0; b < NUM_BINS; b++) begin
            snap_d[b] = live_inc[b];
          end
          state_d     = S_DRAIN;
          out_bin_d   = '0;
          out_count_d = live_inc[0];
        end
      end
      S_DRAIN: begin
        // A close on the final-handshake edge still sees DRAIN and is dropped.
        ovr_inc = win_close;
        if (out_ready) begin
          if (out_bin_q == BIN_WIDTH'(NUM_BINS - 1)) begin
            state_d     = S_IDLE;
            out_bin_d   = '0;
            out_count_d = '0;
          end else begin
            out_bin_d   = bin_next;
            out_count_d = snap_q[bin_next];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      out_bin_q   <= '0;
      out_count_q <= '0;
      for (int b = 0; b < NUM_BINS; b++) begin
        snap_q[b] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_bin_q   <= out_bin_d;
      out_count_q <= out_count_d;
      for (int b = 0; b < NUM_BINS; b++) begin
        snap_q[b] <= snap_d[b];
      end
    end
  end

  assign out_valid = (state_q == S_DRAIN);
  assign out_bin   = out_bin_q;
  assign out_count = out_count_q;
  assign out_last  = out_valid && (out_bin_q == BIN_WIDTH'(NUM_BINS - 1));

endmodule

// File: tb/tb_dtree_class_histogram.sv
// Directed bench: window=4 instance for stream/backpressure/overrun/reset, 3-bit instance for saturation.
module tb_dtree_class_histogram;

  typedef logic [7:0] bins_t [16];

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] level, path;
  logic       in_valid, out_ready;
  logic [3:0] out_bin;
  logic [7:0] out_count;
  logic       out_valid, out_last;
  logic [7:0] overrun;

  logic [1:0] level_s, path_s;
  logic       in_valid_s, out_ready_s;
  logic [3:0] out_bin_s;
  logic [2:0] out_count_s;
  logic       out_valid_s, out_last_s;
  logic [7:0] overrun_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dtree_class_histogram #(.COUNT_WIDTH(8), .WINDOW_EVENTS(4), .OVR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .level(level), .path(path), .in_valid(in_valid),
    .out_bin(out_bin), .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .overrun(overrun)
  );

  dtree_class_histogram #(.COUNT_WIDTH(3), .WINDOW_EVENTS(20), .OVR_WIDTH(8)) dut_sat (
    .clk(clk), .reset(reset), .level(level_s), .path(path_s), .in_valid(in_valid_s),
    .out_bin(out_bin_s), .out_count(out_count_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
    .out_last(out_last_s), .overrun(overrun_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic feed(input logic [1:0] lv, input logic [1:0] pt, input int n);
    for (int i = 0; i < n; i++) begin
      level = lv; path = pt; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Consumes one 16-beat stream; bp=1 holds ready low 10 cycles then toggles it.
  task automatic drain_check(input string tag, input bins_t exp, input bit bp);
    int idx = 0;
    int cyc = 0;
    int budget = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [3:0] pb;
    logic [7:0] pc;
    while (!out_valid && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check_eq({tag, "_valid_rise"}, 32'(out_valid), 32'd1);
    while (idx < 16 && cyc < 200) begin
      rdy = bp ? ((cyc >= 10) && (cyc % 2 == 0)) : 1'b1;
      out_ready = rdy;
      check_eq({tag, "_valid_hold"}, 32'(out_valid), 32'd1);
      if (stalled) begin
        check_eq({tag, "_stall_bin"}, 32'(out_bin), 32'(pb));
        check_eq({tag, "_stall_cnt"}, 32'(out_count), 32'(pc));
      end
      if (out_valid && rdy) begin
        check_eq({tag, "_bin"}, 32'(out_bin), 32'(idx));
        check_eq({tag, "_cnt"}, 32'(out_count), 32'(exp[idx]));
        check_eq({tag, "_last"}, 32'(out_last), (idx == 15) ? 32'd1 : 32'd0);
        idx++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        pb = out_bin;
        pc = out_count;
      end
      cyc++;
      @(negedge clk);
    end
    check_eq({tag, "_handshakes"}, 32'(idx), 32'd16);
    check_eq({tag, "_valid_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bins_t exp;
    reset = 1'b0;
    level = 2'd0; path = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
    level_s = 2'd0; path_s = 2'd0; in_valid_s = 1'b0; out_ready_s = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_bin", 32'(out_bin), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_cnt", 32'(out_count), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_valid_s", 32'(out_valid_s), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Saturation: 20 events into bin 5 of a 3-bit counter.
    for (int i = 0; i < 20; i++) begin
      level_s = 2'd1; path_s = 2'd1; in_valid_s = 1'b1;
      @(negedge clk);
    end
    in_valid_s = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_eq("sat_valid", 32'(out_valid_s), 32'd1);
      check_eq("sat_bin", 32'(out_bin_s), 32'(k));
      check_eq("sat_cnt", 32'(out_count_s), (k == 5) ? 32'd7 : 32'd0);
      check_eq("sat_last", 32'(out_last_s), (k == 15) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    check_eq("sat_valid_end", 32'(out_valid_s), 32'd0);
    check_eq("sat_ovr", 32'(overrun_s), 32'd0);

    // Basic window of 4 with ready high.
    out_ready = 1'b1;
    feed(2'd1, 2'd2, 2);
    feed(2'd3, 2'd0, 1);
    feed(2'd0, 2'd0, 1);
    check_eq("basic_latency", 32'(out_valid), 32'd1);
    exp = '{default: 8'd0};
    exp[6] = 8'd2; exp[12] = 8'd1; exp[0] = 8'd1;
    drain_check("basic", exp, 1'b0);
    check_eq("basic_ovr", 32'(overrun), 32'd0);

    // Backpressure.
    out_ready = 1'b0;
    feed(2'd2, 2'd1, 3);
    feed(2'd0, 2'd3, 1);
    exp = '{default: 8'd0};
    exp[9] = 8'd3; exp[3] = 8'd1;
    drain_check("bp", exp, 1'b1);

    // Overrun: second window closes while the first is still undrained.
    out_ready = 1'b0;
    feed(2'd0, 2'd1, 2);
    feed(2'd2, 2'd2, 1);
    feed(2'd3, 2'd3, 1);
    feed(2'd1, 2'd1, 4);
    check_eq("ovr_count", 32'(overrun), 32'd1);
    check_eq("ovr_bin_held", 32'(out_bin), 32'd0);
    exp = '{default: 8'd0};
    exp[1] = 8'd2; exp[10] = 8'd1; exp[15] = 8'd1;
    drain_check("ovr", exp, 1'b0);

    // Next window closes exactly on the bin-15 handshake edge.
    out_ready = 1'b1;
    feed(2'd0, 2'd2, 4);
    for (int cyc = 0; cyc < 16; cyc++) begin
      check_eq("drop_valid", 32'(out_valid), 32'd1);
      check_eq("drop_bin", 32'(out_bin), 32'(cyc));
      check_eq("drop_cnt", 32'(out_count), (cyc == 2) ? 32'd4 : 32'd0);
      level = 2'd3; path = 2'd3; in_valid = (cyc >= 12);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("drop_valid_end", 32'(out_valid), 32'd0);
    check_eq("drop_ovr", 32'(overrun), 32'd2);

    // Reset mid-drain with partial live counts pending.
    feed(2'd2, 2'd1, 4);
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (out_bin == 4'd5) begin
        reset = 1'b0;
        break;
      end
      level = 2'd3; path = 2'd0; in_valid = (cyc < 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("rstmid_reached", 32'(reset), 32'd0);
    @(negedge clk);
    check_eq("rstmid_valid", 32'(out_valid), 32'd0);
    check_eq("rstmid_ovr", 32'(overrun), 32'd0);
    check_eq("rstmid_bin", 32'(out_bin), 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rstmid_no_beats", 32'(out_valid), 32'd0);
    feed(2'd0, 2'd3, 4);
    exp = '{default: 8'd0};
    exp[3] = 8'd4;
    drain_check("post_rst", exp, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
